// File: rtl/seg7_pkg.sv
// seg7_pkg: segment glyphs, FSM state type and the hex glyph encoder shared
// by the frame writer and its BCD converter.
// Segment vectors are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CONVERT,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-cycle iterative double-dabble, 16-bit binary to 4-digit BCD.
// start loads the operand and clears the BCD register; done is high during the
// final iteration so the caller can leave on the same edge that completes it.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  // add 3 to every BCD nibble of 5 or more ahead of the shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // load on start, otherwise one shift-and-count step per busy cycle
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[14:0], bin_q[15]};
      bin_d = {bin_q[14:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd15) busy_d = 1'b0;
    end
  end

  // converter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == 5'd15);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_frame_writer.sv
// seg7_frame_writer: takes a 16-bit value over valid/ready and writes four
// 7-segment digits (hex or decimal) into the display controller, one digit per
// en_w strobe, digit 0 first.
// Build macro SEG7_LZ_BLANK_EN: when defined, leading zero digits (never digit 0,
// never on overflow frames) are written blank.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a frame, in_ready high
// S_CHECK   | decimal range check; starts the BCD converter if in range
// S_CONVERT | double-dabble running
// S_WRITE   | one digit written this cycle, en_w high
// S_GAP     | en_w low spacing between digit writes
// S_DONE    | done pulse, in_ready high, a new frame may be accepted
module seg7_frame_writer
  import seg7_pkg::*;
#(
  parameter int HOLD_CYCLES = 0,
  parameter int DEC_MAX     = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] value,
  input  logic        dec_mode,
  input  logic [3:0]  dp_mask,
  output logic        en_w,
  output logic [1:0]  waddr,
  output logic [7:0]  data,
  output logic        done
);

  localparam logic [7:0]  GAP_LOAD  = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  localparam logic [16:0] DEC_MAX_W = 17'(DEC_MAX);

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic        dec_q, dec_d;
  logic [3:0]  dp_q, dp_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  gap_q, gap_d;
  logic [1:0]  waddr_q, waddr_d;
  logic [7:0]  data_q, data_d;

  logic        accept;
  logic        over;
  logic        bcd_start, bcd_busy, bcd_done;
  logic [15:0] bcd;

  logic [3:0][3:0] nib;
  logic [3:0]      lz;
  logic [6:0]      cur_seg;
  logic [7:0]      wr_data;

  assign accept    = in_valid && in_ready;
  assign over      = ({1'b0, value_q} > DEC_MAX_W);
  assign bcd_start = (state_q == S_CHECK) && !over;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (value_q),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = dec_mode ? S_CHECK : S_WRITE;
        else        state_d = S_IDLE;
      end
      S_CHECK:   state_d = over ? S_WRITE : S_CONVERT;
      // the !busy exit keeps the FSM from stalling if the converter is idle
      S_CONVERT: if (bcd_done || !bcd_busy) state_d = S_WRITE;
      S_WRITE: begin
        if (digit_q == 2'd3)      state_d = S_DONE;
        else if (HOLD_CYCLES > 0) state_d = S_GAP;
        else                      state_d = S_WRITE;
      end
      S_GAP:   if (gap_q == 8'd0) state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  // glyph for the digit being written: overflow dash, blank, or encoded nibble
  always_comb begin
    nib = dec_q ? bcd : value_q;
    lz  = '0;
`ifdef SEG7_LZ_BLANK_EN
    lz[3] = (nib[3] == 4'd0);
    lz[2] = lz[3] && (nib[2] == 4'd0);
    lz[1] = lz[2] && (nib[1] == 4'd0);
`endif
    if (ovf_q)            cur_seg = SEG_DASH;
    else if (lz[digit_q]) cur_seg = SEG_BLANK;
    else                  cur_seg = enc(nib[digit_q]);
    wr_data = {dp_q[digit_q], cur_seg};
  end

  // frame capture, digit sequencing, gap down-counter and held write port
  always_comb begin
    value_d = value_q;
    dec_d   = dec_q;
    dp_d    = dp_q;
    ovf_d   = ovf_q;
    digit_d = digit_q;
    gap_d   = gap_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    if (accept) begin
      value_d = value;
      dec_d   = dec_mode;
      dp_d    = dp_mask;
      ovf_d   = 1'b0;
    end
    case (state_q)
      S_CHECK: begin
        ovf_d   = over;
        digit_d = '0;
      end
      S_WRITE: begin
        digit_d = digit_q + 2'd1;
        gap_d   = GAP_LOAD;
        waddr_d = digit_q;
        data_d  = wr_data;
      end
      S_GAP: if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
      S_CONVERT: digit_d = '0;
      default: digit_d = '0;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      dec_q   <= 1'b0;
      dp_q    <= '0;
      ovf_q   <= 1'b0;
      digit_q <= '0;
      gap_q   <= '0;
      waddr_q <= '0;
      data_q  <= 8'h7F;
    end else begin
      value_q <= value_d;
      dec_q   <= dec_d;
      dp_q    <= dp_d;
      ovf_q   <= ovf_d;
      digit_q <= digit_d;
      gap_q   <= gap_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  // outputs: live write port in S_WRITE, last written values elsewhere
  always_comb begin
    in_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    done     = (state_q == S_DONE);
    en_w     = (state_q == S_WRITE);
    waddr    = en_w ? digit_q : waddr_q;
    data     = en_w ? wr_data : data_q;
  end

endmodule

// File: tb/tb_seg7_frame_writer.sv
// tb_seg7_frame_writer: directed and random frames against a digit-level model,
// on one instance with HOLD_CYCLES=0 and one with HOLD_CYCLES=2.
module tb_seg7_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] value = '0;
  logic        dec_mode = 1'b0;
  logic [3:0]  dp_mask = '0;

  logic        iv0, iv2, rdy0, rdy2, en0, en2, dn0, dn2;
  logic [1:0]  wa0, wa2;
  logic [7:0]  d0, d2;
  logic        rdy, en, dn;
  logic [1:0]  wa;
  logic [7:0]  d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign iv0 = in_valid & ~sel;
  assign iv2 = in_valid & sel;
  assign rdy = sel ? rdy2 : rdy0;
  assign en  = sel ? en2  : en0;
  assign dn  = sel ? dn2  : dn0;
  assign wa  = sel ? wa2  : wa0;
  assign d   = sel ? d2   : d0;

  seg7_frame_writer #(.HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .value(value),
    .dec_mode(dec_mode), .dp_mask(dp_mask), .en_w(en0), .waddr(wa0),
    .data(d0), .done(dn0)
  );

  seg7_frame_writer #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .value(value),
    .dec_mode(dec_mode), .dp_mask(dp_mask), .en_w(en2), .waddr(wa2),
    .data(d2), .done(dn2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // active-low glyphs, bit0 = a ... bit6 = g
  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return g[v];
  endfunction

  // digit i of the displayed frame, {dot, seg}
  function automatic logic [7:0] model_data(input int v, input bit dm,
                                            input logic [3:0] dp, input int i);
    int part;
    logic [6:0] seg;
    if (dm && v > 9999) begin
      seg = 7'h3F;
    end else begin
      part = dm ? v / (10 ** i) : v >> (4 * i);
      seg  = glyph(dm ? part % 10 : part % 16);
`ifdef SEG7_LZ_BLANK_EN
      if (i > 0 && part == 0) seg = 7'h7F;
`endif
    end
    return {dp[i], seg};
  endfunction

  // call at a negedge with the selected DUT ready; returns at the done-cycle negedge
  task automatic run_frame(input logic [15:0] v, input bit dm, input logic [3:0] dp,
                           input int hold, input bit poke);
    int nw, first, done_c;
    chk("ready_before", rdy, 1);
    value = v; dec_mode = dm; dp_mask = dp; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    value = 16'($urandom); dec_mode = 1'($urandom); dp_mask = 4'($urandom);
    first  = !dm ? 1 : (v > 16'd9999 ? 2 : 18);
    nw     = 0;
    done_c = -1;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge clk);
      if (poke && c >= 2 && c <= 9) begin
        chk("busy_not_ready", rdy, 0);
        in_valid = 1'b1;
      end else if (poke && c == 10) begin
        in_valid = 1'b0;
      end
      if (en) begin
        chk("wr_count_ok", nw < 4, 1);
        if (nw < 4) begin
          chk("wr_cycle", c, first + nw * (hold + 1));
          chk("wr_addr", wa, nw);
          chk("wr_data", d, model_data(v, dm, dp, nw));
        end
        nw++;
      end
      if (dn) begin
        done_c = c;
        chk("done_ready", rdy, 1);
        chk("hold_addr", wa, 3);
        chk("hold_data", d, model_data(v, dm, dp, 3));
      end
    end
    chk("writes", nw, 4);
    chk("done_cycle", done_c, first + 3 * (hold + 1) + 1);
  endtask

  initial begin
    int pulses;
    logic [15:0] rv;
    bit rdm;

    repeat (2) @(negedge clk);
    chk("rst_ready0", rdy0, 1); chk("rst_en0", en0, 0); chk("rst_addr0", wa0, 0);
    chk("rst_data0", d0, 8'h7F); chk("rst_done0", dn0, 0);
    chk("rst_ready2", rdy2, 1); chk("rst_en2", en2, 0); chk("rst_addr2", wa2, 0);
    chk("rst_data2", d2, 8'h7F); chk("rst_done2", dn2, 0);
    rst = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    run_frame(16'hA3F1, 1'b0, 4'b0001, 0, 1'b0); @(negedge clk);
    run_frame(16'd1234, 1'b1, 4'b0000, 0, 1'b0); @(negedge clk);
    run_frame(16'd10000, 1'b1, 4'b1000, 0, 1'b0); @(negedge clk);
    run_frame(16'd7,     1'b1, 4'b0000, 0, 1'b0); @(negedge clk);
    run_frame(16'd0,     1'b1, 4'b0101, 0, 1'b0); @(negedge clk);
    run_frame(16'd9999,  1'b1, 4'b1111, 0, 1'b0); @(negedge clk);
    run_frame(16'hFFFF,  1'b0, 4'b0010, 0, 1'b0);
    run_frame(16'h0070,  1'b0, 4'b0000, 0, 1'b0); @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      rdm = 1'($urandom);
      rv  = 16'($urandom);
      if (rdm && ($urandom_range(0, 3) != 0)) rv = 16'($urandom_range(0, 9999));
      run_frame(rv, rdm, 4'($urandom), 0, 1'b0);
      if (k % 2 == 0) @(negedge clk);
    end
    @(negedge clk);

    // reset in the fifth CONVERT cycle
    value = 16'd4321; dec_mode = 1'b1; dp_mask = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (en) pulses++;
    end
    rst = 1'b0;
    #1;
    chk("midrst_ready", rdy, 1); chk("midrst_en", en, 0); chk("midrst_addr", wa, 0);
    chk("midrst_data", d, 8'h7F); chk("midrst_done", dn, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (en) pulses++;
    end
    chk("midrst_no_writes", pulses, 0);
    run_frame(16'd560, 1'b1, 4'b0010, 0, 1'b0); @(negedge clk);

    sel = 1'b1;
    @(negedge clk);
    run_frame(16'h0000, 1'b0, 4'b0000, 2, 1'b1);
    run_frame(16'($urandom), 1'b0, 4'($urandom), 2, 1'b0); @(negedge clk);
    run_frame(16'($urandom_range(0, 9999)), 1'b1, 4'($urandom), 2, 1'b0); @(negedge clk);
    run_frame(16'd12345, 1'b1, 4'b1001, 2, 1'b0); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_frame_writer.md
Name: seg7_frame_writer

Overview:
- Upstream feeder for LED_7SEG_Controller.
- Accepts a 16-bit value over a valid/ready handshake, plus a mode select and a per-digit dot mask.
- In hex mode, each nibble is encoded to an active-low 7-segment pattern. In decimal mode, the value is first converted to BCD by an iterative double-dabble.
- The four digits are then written into the controller's digit registers through its en_w/waddr/data write port, one digit per write.

Parameters:
- HOLD_CYCLES, 0, idle cycles with en_w low inserted between consecutive digit writes (0..255).
- DEC_MAX, 9999, largest value displayable in decimal mode; values above it produce the overflow frame.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  request carries a new frame.
- in_ready  output  1  block idle and able to accept a frame.
- value  input  16  number to display.
- dec_mode  input  1  0 = hex, 1 = decimal.
- dp_mask  input  4  dot bit per digit; bit i goes to digit i.
- en_w  output  1  write strobe to the controller.
- waddr  output  2  digit index written (0 = least significant digit).
- data  output  8  {dot, seg[6:0]}; seg is active-low with bit0 = a ... bit6 = g.
- done  output  1  one-cycle pulse after the last write of a frame.

Behaviour:
- Reset values (reset asserted): in_ready=1, en_w=0, waddr=0, data=8'h7F (blank, dot 0), done=0, FSM=IDLE.
- Handshake:
  - A frame is accepted on a rising edge where in_valid=1 and in_ready=1. value, dec_mode and dp_mask are captured at that edge.
  - in_ready drops the following cycle.
  - in_valid while in_ready=0 is ignored, with no queuing.
- FSM states: IDLE, CHECK, CONVERT, WRITE, GAP, DONE.
- IDLE:
  - On accept with dec_mode=0, go to WRITE.
  - On accept with dec_mode=1, go to CHECK.
- CHECK (one cycle):
  - If value > DEC_MAX, set the overflow flag and go to WRITE; every digit then uses the dash pattern 7'b0111111.
  - Otherwise, clear the 16-bit BCD register and go to CONVERT.
- CONVERT:
  - Runs 16 cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1.
  - A 5-bit iteration counter starts at 0; leave for WRITE when it reaches 15.
- WRITE:
  - Exactly one cycle per digit: en_w=1, waddr=i, data={dp_mask[i], enc(digit i)}.
  - Digits are written in order i = 0, 1, 2, 3.
  - After digit 3, go to DONE. Otherwise, go to GAP if HOLD_CYCLES>0, else stay in WRITE for the next digit.
- GAP: holds en_w=0 for HOLD_CYCLES cycles, then returns to WRITE.
- DONE (one cycle): done=1, in_ready=1, then go to IDLE. A frame presented in the DONE cycle is accepted.
- Output values outside WRITE: en_w=0; waddr and data keep their last values.
- Latency with HOLD_CYCLES=0, accept edge = cycle 0:
  - Hex: writes in cycles 1–4, done in cycle 5.
  - Decimal: CHECK in cycle 1, CONVERT in cycles 2–17, writes in cycles 18–21, done in cycle 22.
  - Decimal overflow: CHECK in cycle 1, writes in cycles 2–5, done in cycle 6.
- Encoding:
  - Hex digits use the 16 patterns 0–F.
  - BCD nibbles are always 0–9 by construction.
  - Dots pass through unmodified, including on overflow frames.
- Reset mid-frame: all state and outputs return to their reset values immediately. Digits already written stay in the controller; no partial writes resume.
- value=0 in decimal mode writes "0000" (subject to the optional feature).

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking. Scanning from digit 3 downward, each zero digit is written as 7'b1111111 until the first non-zero digit; digit 0 is never blanked. Applies in both modes, not to overflow frames. Dot bits are unaffected.
- Undefined: all four digits are always written with their glyphs.

Decomposition:
- Package seg7_pkg: the 16 hex segment constants, SEG_DASH (7'b0111111), SEG_BLANK (7'b1111111), the FSM state enum, and an enc() function.
- Sub-module bin2bcd_seq: start/busy/done handshake, 16-bit binary in, 16-bit BCD out, 16-cycle double-dabble. The frame writer drives its start in CHECK and waits on its done.

Test Plan:
- Hex, value=16'hA3F1, dp_mask=4'b0001 -> writes (waddr,data) = (0,0xF9), (1,0x0E), (2,0x30), (3,0x08) on consecutive cycles 1–4; done in cycle 5.
- Decimal, value=1234, dp_mask=0 -> first en_w in cycle 18; writes (0,0x19), (1,0x30), (2,0x24), (3,0x79).
- Decimal, value=10000, dp_mask=4'b1000 -> writes 0x3F, 0x3F, 0x3F, 0xBF in cycles 2–5.
- Decimal, value=7 -> with SEG7_LZ_BLANK_EN: 0x78, 0x7F, 0x7F, 0x7F; without it: 0x78, 0x40, 0x40, 0x40.
- HOLD_CYCLES=2, hex 16'h0000 -> en_w high in cycles 1, 4, 7, 10; a second in_valid during cycles 2–9 is ignored; a new frame is accepted in the done cycle.
- Reset asserted in CONVERT cycle 5 -> en_w never pulses; in_ready=1 and data=0x7F immediately; the next frame runs normally after rst=1.
